// File: rtl/prince_sbox_cms_pipe_if.sv
// Handshake and share bus for the masked PRINCE S-box layer.
// The master side produces input shares and consumes output shares;
// the slave side is the S-box pipeline itself.
interface prince_sbox_cms_pipe_if #(
    parameter int NIBBLES = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_inv;
    logic [4*NIBBLES-1:0]    in_sh0;
    logic [4*NIBBLES-1:0]    in_sh1;
    logic [64*NIBBLES-1:0]   in_rand;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*NIBBLES-1:0]    out_sh0;
    logic [4*NIBBLES-1:0]    out_sh1;

    modport master (
        output in_valid, in_inv, in_sh0, in_sh1, in_rand, out_ready,
        input  in_ready, out_valid, out_sh0, out_sh1
    );

    modport slave (
        input  in_valid, in_inv, in_sh0, in_sh1, in_rand, out_ready,
        output in_ready, out_valid, out_sh0, out_sh1
    );
endinterface

// File: rtl/prince_sbox_cms_pipe.sv
// First-order CMS-masked PRINCE S-box layer, two shares in, two shares out.
// Stage 1 evaluates the 16 non-complete component functions of every output
// bit (forward and inverse in parallel) and adds a ring refresh; stage 2
// compresses components 0..7 into share 0 and 8..15 into share 1.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; a producer holds valid and its payload stable until that edge, and
// ready may depend combinationally on the consumer's ready but never on valid.
module prince_sbox_cms_pipe #(
    parameter int NIBBLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    prince_sbox_cms_pipe_if.slave   bus
);
    localparam int RAND_PER_NIB = 64;
    localparam int W            = 4 * NIBBLES;
    localparam int CW           = RAND_PER_NIB * NIBBLES;

    // Lookup tables, entry v at bits [4v+3:4v].
    localparam logic [63:0] SBOX_F = 64'h4D5E_0876_19CA_23FB;
    localparam logic [63:0] SBOX_I = 64'h1CE5_046A_98DF_237B;

    // Moebius transform of each output bit; result bit 16*b+m is the ANF
    // coefficient of monomial m (m[3]=x .. m[0]=w) for output bit b.
    function automatic logic [63:0] anf_of(input logic [63:0] tbl);
        logic [15:0] a;
        logic [63:0] res;
        res = '0;
        a   = '0;
        for (int b = 0; b < 4; b++) begin
            for (int v = 0; v < 16; v++) a[v] = tbl[4*v+b];
            for (int s = 0; s < 4; s++)
                for (int v = 0; v < 16; v++)
                    if (v[s]) a[v] = a[v] ^ a[v ^ (1 << s)];
            res[16*b +: 16] = a;
        end
        return res;
    endfunction

    localparam logic [63:0] ANF_F = anf_of(SBOX_F);
    localparam logic [63:0] ANF_I = anf_of(SBOX_I);

    // Component idx: variable k is taken from share idx[k]. A monomial belongs
    // here only when every absent variable has index bit 0, so the constant
    // term lands in component 0 and each component sees one share per variable.
    function automatic logic comp(input logic [15:0] anf, input logic [3:0] idx,
                                  input logic [3:0] a0, input logic [3:0] a1);
        logic acc;
        logic t;
        acc = 1'b0;
        for (int m = 0; m < 16; m++) begin
            t = anf[m] && ((idx & ~4'(m)) == 4'd0);
            for (int k = 0; k < 4; k++)
                if (m[k]) t = t & (idx[k] ? a1[k] : a0[k]);
            acc = acc ^ t;
        end
        return acc;
    endfunction

    logic          v1_q, v2_q, inv1_q;
    logic          advance, in_fire;
    logic [CW-1:0] cf_d, ci_d, cf_q, ci_q;
    logic [W-1:0]  o0_d, o1_d, o0_q, o1_q;

    assign advance      = ~v2_q | bus.out_ready;
    assign bus.in_ready = advance | ~v1_q;
    assign in_fire      = bus.in_valid & bus.in_ready;

    assign bus.out_valid = v2_q;
    assign bus.out_sh0   = o0_q;
    assign bus.out_sh1   = o1_q;

    for (genvar n = 0; n < NIBBLES; n++) begin : g_nib
        for (genvar b = 0; b < 4; b++) begin : g_bit
            localparam int BASE = RAND_PER_NIB * n + 16 * b;
            for (genvar i = 0; i < 16; i++) begin : g_cmp
                localparam int NXT = (i + 1) % 16;
                // Ring refresh: r[i] ^ r[i+1] summed over all 16 cancels out.
                assign cf_d[BASE+i] = comp(ANF_F[16*b +: 16], 4'(i),
                                           bus.in_sh0[4*n +: 4], bus.in_sh1[4*n +: 4])
                                      ^ bus.in_rand[BASE+i] ^ bus.in_rand[BASE+NXT];
                assign ci_d[BASE+i] = comp(ANF_I[16*b +: 16], 4'(i),
                                           bus.in_sh0[4*n +: 4], bus.in_sh1[4*n +: 4])
                                      ^ bus.in_rand[BASE+i] ^ bus.in_rand[BASE+NXT];
            end
            // Compression; the public inverse flag only selects which set.
            assign o0_d[4*n+b] = inv1_q ? ^ci_q[BASE +: 8]   : ^cf_q[BASE +: 8];
            assign o1_d[4*n+b] = inv1_q ? ^ci_q[BASE+8 +: 8] : ^cf_q[BASE+8 +: 8];
        end
    end

    // Stage 1: capture refreshed components on an accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            inv1_q <= 1'b0;
            cf_q   <= '0;
            ci_q   <= '0;
        end else if (in_fire) begin
            v1_q   <= 1'b1;
            inv1_q <= bus.in_inv;
            cf_q   <= cf_d;
            ci_q   <= ci_d;
        end else if (advance) begin
            v1_q   <= 1'b0;
        end
    end

    // Stage 2: compressed output shares, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            o0_q <= '0;
            o1_q <= '0;
        end else if (advance) begin
            v2_q <= v1_q;
            if (v1_q) begin
                o0_q <= o0_d;
                o1_q <= o1_d;
            end
        end
    end
endmodule

// File: tb/tb_prince_sbox_cms_pipe.sv
// Directed and random checks of the masked PRINCE S-box pipeline against an
// unmasked table model, with a scoreboard queue between input and output.
module tb_prince_sbox_cms_pipe;
    localparam int NIB = 16;
    localparam int W   = 4 * NIB;
    localparam int RW  = 64 * NIB;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   out_cnt = 0;
    int   ready_drops = 0;
    bit   rnd_ready = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] sh0_log[$];
    int           acc_cyc_q[$];
    int           out_cyc_q[$];
    logic [W-1:0] exp_t;

    logic [3:0] sfwd [16] = '{4'hB,4'hF,4'h3,4'h2,4'hA,4'hC,4'h9,4'h1,
                              4'h6,4'h7,4'h8,4'h0,4'hE,4'h5,4'hD,4'h4};
    logic [3:0] sinv [16] = '{4'hB,4'h7,4'h3,4'h2,4'hF,4'hD,4'h8,4'h9,
                              4'hA,4'h6,4'h4,4'h0,4'h5,4'hE,4'hC,4'h1};

    prince_sbox_cms_pipe_if #(.NIBBLES(NIB)) bus ();

    prince_sbox_cms_pipe #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic inv, input logic [W-1:0] s0,
                                           input logic [W-1:0] s1);
        logic [W-1:0] r;
        logic [3:0]   v;
        r = '0;
        for (int n = 0; n < NIB; n++) begin
            v = s0[4*n +: 4] ^ s1[4*n +: 4];
            r[4*n +: 4] = inv ? sinv[v] : sfwd[v];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_w();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [RW-1:0] rand_r();
        logic [RW-1:0] r;
        for (int k = 0; k < RW / 32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard: pop/compare on output transfers, push on input transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                out_cyc_q.push_back(cyc);
                sh0_log.push_back(bus.out_sh0);
                chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t = exp_q.pop_front();
                    chk("sbox_out", bus.out_sh0 ^ bus.out_sh1, exp_t);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_inv, bus.in_sh0, bus.in_sh1));
                acc_cyc_q.push_back(cyc);
            end
        end
    end

    // Drive one transfer and hold it until accepted (bounded).
    task automatic send(input logic inv, input logic [W-1:0] s0, input logic [W-1:0] s1,
                        input logic [RW-1:0] r);
        bit acc;
        int n;
        bus.in_inv   = inv;
        bus.in_sh0   = s0;
        bus.in_sh1   = s1;
        bus.in_rand  = r;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (!acc) ready_drops++;
            @(posedge clk);
            #1;
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        rnd_ready     = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic [W-1:0]  bp_s0 [3];
    logic [W-1:0]  bp_s1 [3];
    logic [RW-1:0] bp_r  [3];
    logic          bp_inv[3];
    logic [W-1:0]  snap0, snap1;
    logic [3:0]    nv;
    int            acc_n, idx, cnt_snap;
    bit            a;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inv    = 1'b0;
        bus.in_sh0    = '0;
        bus.in_sh1    = '0;
        bus.in_rand   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_sh0", bus.out_sh0, 64'd0);
        chk("rst_out_sh1", bus.out_sh1, 64'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Forward exhaustive, unmasked-in-share-0, no randomness.
        bus.out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            nv = 4'(v);
            send(1'b0, {NIB{nv}}, '0, '0);
        end
        drain();

        // Refresh: same input, different randomness -> shares move, XOR fixed.
        sh0_log.delete();
        send(1'b0, {NIB{4'h5}}, '0, '0);
        send(1'b0, {NIB{4'h5}}, '0, {(RW/16){16'h0001}});
        send(1'b0, {NIB{4'h5}}, '0, rand_r());
        drain();
        chk("refresh_log_len", 64'(sh0_log.size()), 64'd3);
        if (sh0_log.size() == 3) begin
            chk("refresh_sh0_plain", sh0_log[0], {NIB{4'hC}});
            chk("refresh_sh0_flipped", sh0_log[1], ~sh0_log[0]);
        end

        // Inverse with random shares and randomness under random backpressure.
        rnd_ready = 1'b1;
        for (int k = 0; k < 10000; k++) send(1'b1, rand_w(), rand_w(), rand_r());
        drain();

        // Back-to-back stream at full rate.
        acc_cyc_q.delete();
        out_cyc_q.delete();
        ready_drops = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) send(1'($urandom_range(0, 1)), rand_w(), rand_w(), rand_r());
        drain();
        chk("b2b_ready_drops", 64'(ready_drops), 64'd0);
        chk("b2b_acc_count", 64'(acc_cyc_q.size()), 64'd20);
        chk("b2b_out_count", 64'(out_cyc_q.size()), 64'd20);
        if (acc_cyc_q.size() == 20 && out_cyc_q.size() == 20) begin
            for (int k = 0; k < 20; k++) begin
                chk("b2b_latency", 64'(out_cyc_q[k] - acc_cyc_q[k]), 64'd2);
                chk("b2b_consecutive", 64'(out_cyc_q[k] - out_cyc_q[0]), 64'(k));
            end
        end

        // Backpressure: three offered while downstream stalls for 5 cycles.
        for (int k = 0; k < 3; k++) begin
            bp_s0[k]  = rand_w();
            bp_s1[k]  = rand_w();
            bp_r[k]   = rand_r();
            bp_inv[k] = 1'($urandom_range(0, 1));
        end
        cnt_snap      = out_cnt;
        bus.out_ready = 1'b0;
        acc_n = 0;
        idx   = 0;
        snap0 = '0;
        snap1 = '0;
        bus.in_inv   = bp_inv[0];
        bus.in_sh0   = bp_s0[0];
        bus.in_sh1   = bp_s1[0];
        bus.in_rand  = bp_r[0];
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a = bus.in_ready;
            if (a) acc_n++;
            if (c == 2) begin
                snap0 = bus.out_sh0;
                snap1 = bus.out_sh1;
            end
            @(posedge clk);
            #1;
            if (a && idx < 2) begin
                idx++;
                bus.in_inv  = bp_inv[idx];
                bus.in_sh0  = bp_s0[idx];
                bus.in_sh1  = bp_s1[idx];
                bus.in_rand = bp_r[idx];
            end
        end
        chk("bp_accepted", 64'(acc_n), 64'd2);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
        chk("bp_sh0_stable", bus.out_sh0, snap0);
        chk("bp_sh1_stable", bus.out_sh1, snap1);
        chk("bp_nothing_out", 64'(out_cnt - cnt_snap), 64'd0);
        bus.out_ready = 1'b1;
        send(bp_inv[2], bp_s0[2], bp_s1[2], bp_r[2]);
        drain();
        chk("bp_drained_count", 64'(out_cnt - cnt_snap), 64'd3);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        send(1'b0, rand_w(), rand_w(), rand_r());
        send(1'b1, rand_w(), rand_w(), rand_r());
        bus.in_valid = 1'b0;
        chk("pre_rst_v2", 64'(bus.out_valid), 64'd1);
        chk("pre_rst_v1_blocks", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_sh0", bus.out_sh0, 64'd0);
        chk("midrst_out_sh1", bus.out_sh1, 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        cnt_snap = out_cnt;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(out_cnt - cnt_snap), 64'd0);
        chk("midrst_idle_valid", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prince_sbox_cms_pipe.md
Name: prince_sbox_cms_pipe

Overview:
- First-order CMS-masked PRINCE S-box layer for NIBBLES parallel nibbles.
- Two input shares, two output shares, forward or inverse S-box selectable per transfer.
- Two-stage registered pipeline:
  - stage 1: 16 non-complete component functions per output bit, plus ring refresh;
  - stage 2: compression back to 2 shares.
- Sits in the masked PRINCE round datapath between key/constant addition and the linear layer. Valid/ready handshake on both sides.

Parameters:
- NIBBLES, 16, number of parallel 4-bit S-box instances; legal range 1..16.
- RAND_PER_NIB, 64, fresh random bits consumed per nibble per transfer; fixed at 16 bits per output bit; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input transfer request.
- in_ready  out  1  block can accept; in_valid & in_ready = transfer.
- in_inv  in  1  0 = forward S, 1 = inverse S^-1; travels with the data.
- in_sh0  in  4*NIBBLES  share 0; nibble n = bits [4n+3:4n]; bit 3 = x, bit 0 = w.
- in_sh1  in  4*NIBBLES  share 1, same layout.
- in_rand  in  64*NIBBLES  fresh randomness; nibble n uses [64n+63:64n]; output bit b uses sub-slice [16b+15:16b].
- out_valid  out  1  output shares valid.
- out_ready  in  1  downstream accepts.
- out_sh0  out  4*NIBBLES  output share 0.
- out_sh1  out  4*NIBBLES  output share 1.

Behaviour:
- Functions:
  - S = {B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4}.
  - S^-1 = {B,7,3,2,F,D,8,9,A,6,4,0,5,E,C,1}.
  - Each output bit is the cubic ANF of (x,y,z,w), derived from the selected table.
- Correctness invariant: out_sh0 ^ out_sh1 = F(in_sh0 ^ in_sh1) per nibble, F selected by in_inv.
- Component index i in 0..15:
  - bits i[3],i[2],i[1],i[0] select the share index of x,y,z,w.
  - Each ANF monomial goes into component i only if its variables take their share from i and every absent variable's index bit is 0.
  - The constant term goes into component 0 only.
  - Each component therefore sees at most one share of each variable (non-completeness).
- Stage 1 register:
  - c[i] ^ r[i] ^ r[(i+1) mod 16], with r = that bit's 16-bit random slice.
  - in_inv is registered alongside as a plain mux select. It is public; no masking required.
  - No combinational path from an input share to any register without passing a component function.
- Stage 2 register:
  - out_sh0 bit = XOR of refreshed c[0..7].
  - out_sh1 bit = XOR of refreshed c[8..15].
- Pipeline control:
  - Per-stage valid bits v1 and v2.
  - advance = ~v2 | out_ready.
  - in_ready = advance | ~v1.
  - Stage 1 loads on in_valid & in_ready.
  - Stage 2 loads from stage 1 when advance.
  - out_valid = v2.
- Latency and throughput:
  - Latency 2 cycles from accepted input to out_valid.
  - Throughput 1 transfer/cycle when out_ready is held high.
- Stall behaviour:
  - While stalled (v2 & ~out_ready), out_sh0, out_sh1 and out_valid stay stable.
  - Stage 1 holds if v1 is set; it accepts only if v1 is clear.
- Simultaneous accept-in and drain-out in the same cycle is legal and loses no data.
- Reset (rst_n = 0 at a clock edge):
  - v1 = v2 = 0, out_valid = 0, out_sh0 = out_sh1 = 0, all share registers = 0.
  - in_ready = 1 in the first cycle after reset release.
  - Reset mid-operation discards in-flight data; nothing is emitted.
- in_rand is sampled only on an accepted transfer. Reusing randomness is a caller error and is not detected.

Test Plan:
- Forward exhaustive: NIBBLES=1, in_rand=0, in_sh1=0, in_sh0 sweeps 0..F, in_inv=0 -> out_sh0^out_sh1 = S table (e.g. 0->B, 7->1, F->4), each 2 cycles after accept.
- Inverse with random shares: in_inv=1, random in_sh0/in_sh1/in_rand, 10k vectors, NIBBLES=16 -> every nibble of out_sh0^out_sh1 = S^-1(in_sh0^in_sh1); e.g. unmasked 4 -> F, E -> C.
- Refresh effect: fixed input 0x5 with in_rand varied -> XOR of the two output shares is constant C, while out_sh0 alone differs across random values.
- Back-to-back stream: in_valid and out_ready held high for 20 cycles -> 20 outputs on consecutive cycles starting at cycle 2, order preserved, in_ready stays high.
- Backpressure: out_ready=0 for 5 cycles with 3 transfers offered -> 2 accepted, in_ready drops, out_sh* stable; after out_ready=1, outputs drain in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 for one cycle with v1=v2=1 -> next cycle out_valid=0, outputs 0, in_ready=1; no stale result appears afterwards.
